mont_arbiter: RTL and testbench

MONT_ARBITER -- requirements
Module: mont_arbiter

---
 rtl/mont_arbiter.sv | 143 ++++++++++++++
 tb/tb_mont_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_arbiter.sv
// Two-requester arbiter sharing one Montgomery multiplier; round-robin on contention.
// Optional BUSY watchdog enabled by `define MONT_ARBITER_TIMEOUT_EN.
module mont_arbiter #(
  parameter int W = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         err,
  output logic         mult_resetn,
  output logic         mult_start,
  output logic [W-1:0] mult_a,
  output logic [W-1:0] mult_b,
  input  logic         mult_done,
  input  logic [W-1:0] mult_res
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t       r_state;
  logic         r_ptr;
  logic         r_owner;
  logic [W-1:0] r_opa;
  logic [W-1:0] r_opb;
  logic [W-1:0] r_result;
  logic         r_start;
  logic         r_done0;
  logic         r_done1;
  logic         r_busy;
  logic         r_mrstn;
`ifdef MONT_ARBITER_TIMEOUT_EN
  logic [11:0]  r_wd;
  logic         r_err;
`endif

  logic w_gnt_any;
  logic w_sel;

  // Pointer only matters on contention; a lone requester is always served.
  assign w_sel     = (req0 & req1) ? r_ptr : req1;
  assign w_gnt_any = (r_state == IDLE) & (req0 | req1) & ~reset;

  assign gnt0        = w_gnt_any & ~w_sel;
  assign gnt1        = w_gnt_any & w_sel;
  assign done0       = r_done0;
  assign done1       = r_done1;
  assign result      = r_result;
  assign busy        = r_busy;
  assign mult_resetn = r_mrstn;
  assign mult_start  = r_start;
  assign mult_a      = r_opa;
  assign mult_b      = r_opb;
`ifdef MONT_ARBITER_TIMEOUT_EN
  assign err         = r_err;
`else
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_busy   <= 1'b0;
      r_mrstn  <= 1'b0;
`ifdef MONT_ARBITER_TIMEOUT_EN
      r_wd     <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
`ifdef MONT_ARBITER_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_opa   <= w_sel ? a1 : a0;
            r_opb   <= w_sel ? b1 : b0;
            r_owner <= w_sel;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_mrstn <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
`ifdef MONT_ARBITER_TIMEOUT_EN
          r_wd    <= '0;
`endif
          r_state <= BUSY;
        end
        BUSY: begin
          if (mult_done) begin
            r_result <= mult_res;
            r_ptr    <= ~r_owner;
            r_done0  <= ~r_owner;
            r_done1  <= r_owner;
            r_state  <= RESP;
          end
`ifdef MONT_ARBITER_TIMEOUT_EN
          // Terminal count: finish with the old result and flag the timeout.
          else if (r_wd == 12'hFFF) begin
            r_ptr   <= ~r_owner;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_wd <= r_wd + 12'd1;
          end
`endif
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_mrstn <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_arbiter.sv
// Bench for mont_arbiter: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_mont_arbiter;
  localparam int W = 1024;
`ifdef MONT_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, busy, err, mult_resetn, mult_start, mult_done;
  logic [W-1:0] result, mult_a, mult_b, mult_res;

  mont_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .err(err),
    .mult_resetn(mult_resetn), .mult_start(mult_start),
    .mult_a(mult_a), .mult_b(mult_b), .mult_done(mult_done), .mult_res(mult_res)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: done mlat cycles after the start cycle, result = a ^ b.
  int mlat = 10;
  bit mnever = 1'b0;
  int mcnt = 0;
  always @(posedge clk) begin
    if (!mult_resetn)   mcnt <= 0;
    else if (mult_start) mcnt <= mlat;
    else if (mcnt > 0)  mcnt <= mcnt - 1;
  end
  assign mult_done = !mnever && (mcnt == 1);
  assign mult_res  = mult_a ^ mult_b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ..%0h want ..%0h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: one transaction in flight, described by grant cycle and response flag.
  bit           m_act = 0, m_owner = 0, m_ptr = 0, m_resp = 0, m_to = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  int           m_g = 0;
  bit           e_g, e_sel;
  int           e_k;

  always @(negedge clk) begin
    e_g   = !m_act && !reset && (req0 || req1);
    e_sel = (req0 && req1) ? m_ptr : req1;
    chk1("gnt0", gnt0, e_g && !e_sel);
    chk1("gnt1", gnt1, e_g && e_sel);
    chk1("busy", busy, m_act);
    chk1("mult_resetn", mult_resetn, m_act);
    chk1("mult_start", mult_start, m_act && (cyc == m_g + 1));
    chk1("done0", done0, m_resp && !m_owner);
    chk1("done1", done1, m_resp && m_owner);
    chk1("err", err, m_resp && m_to);
    chkw("result", result, m_res);
    if (m_act) begin
      chkw("mult_a", mult_a, m_a);
      chkw("mult_b", mult_b, m_b);
    end
    if (reset) begin
      m_act = 0; m_ptr = 0; m_owner = 0; m_resp = 0; m_to = 0; m_res = '0;
    end else if (!m_act) begin
      if (e_g) begin
        m_act = 1; m_owner = e_sel; m_g = cyc;
        m_a = e_sel ? a1 : a0;
        m_b = e_sel ? b1 : b0;
      end
    end else if (m_resp) begin
      m_act = 0; m_resp = 0; m_to = 0;
    end else if (cyc >= m_g + 2) begin
      e_k = cyc - m_g - 2;
      if (mult_done) begin
        m_res = m_a ^ m_b; m_resp = 1; m_ptr = !m_owner;
      end else if (TO_EN && e_k == 4095) begin
        m_resp = 1; m_to = 1; m_ptr = !m_owner;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(output bit who, output int gc, output bit ok);
    who = 0; gc = 0; ok = 0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (gnt0 || gnt1) begin who = gnt1; gc = cyc; ok = 1; break; end
      tick(); #1;
    end
  endtask

  task automatic wait_done(input int bound, output int dc, output bit derr,
                           output logic [W-1:0] dres, output bit dwho, output bit ok);
    dc = 0; derr = 0; dres = '0; dwho = 0; ok = 0;
    #1;
    for (int i = 0; i < bound; i++) begin
      if (done0 || done1) begin
        dc = cyc; derr = err; dres = result; dwho = done1; ok = 1; break;
      end
      tick(); #1;
    end
  endtask

  bit           who, ok, derr, dwho;
  int           gc, dc;
  logic [W-1:0] dres;
  bit           exp_who [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mult_resetn", mult_resetn, 1'b0);
    chkw("rst_result", result, '0);
    reset = 0;

    // Single request, operand change after the grant
    tick(); a0 = 5; b0 = 3; req0 = 1;
    wait_gnt(who, gc, ok);
    chk1("t1_gnt_seen", ok, 1'b1);
    chk1("t1_who", who, 1'b0);
    tick(); req0 = 0; a0 = 9;
    wait_done(100, dc, derr, dres, dwho, ok);
    chk1("t1_done_seen", ok, 1'b1);
    chk1("t1_done_owner", dwho, 1'b0);
    chkw("t1_result", dres, W'(6));
    chki("t1_latency", dc - gc, 12);
    tick();

    // Contention right after reset: alternation 0,1,0 with back-to-back grants
    reset = 1; tick(); tick(); reset = 0;
    a0 = 7; b0 = 1; a1 = 2; b1 = 8; req0 = 1; req1 = 1;
    for (int n = 0; n < 3; n++) begin
      wait_gnt(who, gc, ok);
      chk1("t2_gnt_seen", ok, 1'b1);
      chk1("t2_order", who, exp_who[n]);
      if (n > 0) chki("t2_back_to_back", gc - dc, 1);
      tick();
      if (n == 2) begin req0 = 0; req1 = 0; end
      wait_done(100, dc, derr, dres, dwho, ok);
      chk1("t2_done_owner", dwho, exp_who[n]);
      chkw("t2_result", dres, exp_who[n] ? W'(10) : W'(6));
      tick();
    end

    // Reset in BUSY abandons the operation
    a0 = 3; b0 = 4; req0 = 1;
    wait_gnt(who, gc, ok);
    tick(); req0 = 0;
    repeat (4) tick();
    reset = 1; tick(); reset = 0;
    chk1("t3_busy", busy, 1'b0);
    chk1("t3_mult_resetn", mult_resetn, 1'b0);
    chkw("t3_result", result, '0);
    tick(); a0 = 12; b0 = 3; req0 = 1;
    wait_gnt(who, gc, ok);
    chk1("t3_regrant", ok && !who, 1'b1);
    tick(); req0 = 0;
    wait_done(100, dc, derr, dres, dwho, ok);
    chkw("t3_result_after", dres, W'(15));
    tick();

`ifdef MONT_ARBITER_TIMEOUT_EN
    mnever = 1; a0 = 1; b0 = 2; req0 = 1;
    wait_gnt(who, gc, ok);
    tick(); req0 = 0;
    wait_done(5000, dc, derr, dres, dwho, ok);
    chk1("t4_done_seen", ok, 1'b1);
    chk1("t4_err", derr, 1'b1);
    chkw("t4_result_kept", dres, W'(15));
    chki("t4_latency", dc - gc, 4098);
    tick();
    mnever = 0; mlat = 4096; a0 = 6; b0 = 5; req0 = 1;
    wait_gnt(who, gc, ok);
    tick(); req0 = 0;
    wait_done(5000, dc, derr, dres, dwho, ok);
    chk1("t5_done_seen", ok, 1'b1);
    chk1("t5_err", derr, 1'b0);
    chkw("t5_result", dres, W'(3));
    chki("t5_latency", dc - gc, 4098);
    tick();
`else
    mnever = 1; a0 = 1; b0 = 2; req0 = 1;
    wait_gnt(who, gc, ok);
    tick(); req0 = 0;
    repeat (5000) tick();
    chk1("t4_still_busy", busy, 1'b1);
    reset = 1; tick(); reset = 0; mnever = 0;
    tick();
    chk1("t4_recovered", busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
